// File: rtl/aes_pkg.sv
// Shared definitions for the AES job scheduler: key-size codes, round counts,
// FSM state encoding and block width.
package aes_pkg;

  localparam int AES_BLK = 128;

  localparam logic [1:0] KSEL_INV = 2'b00;
  localparam logic [1:0] KSEL_128 = 2'b01;
  localparam logic [1:0] KSEL_192 = 2'b10;
  localparam logic [1:0] KSEL_256 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_BUSY,
    ST_RESP
  } state_e;

  // Round count for a key-size code; 0 marks an invalid code.
  function automatic logic [4:0] nr_of(input logic [1:0] ksel);
    case (ksel)
      KSEL_128: nr_of = 5'd10;
      KSEL_192: nr_of = 5'd12;
      KSEL_256: nr_of = 5'd14;
      default:  nr_of = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// the pointer, wrapping, and reports both a one-hot grant and its index.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    any
);

  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0] rot;
  int              pos;

  always_comb begin
    // Rotate so that bit 0 is the requester the pointer names.
    rot = NREQ'({req, req} >> ptr);
    idx = '0;
    any = 1'b0;
    pos = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any && rot[k]) begin
        pos = int'(ptr) + k;
        if (pos >= NREQ) pos = pos - NREQ;
        idx = IW'(pos);
        any = 1'b1;
      end
    end
    grant = any ? (NREQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/aes_job_scheduler.sv
// Shares one iterative AES engine between NREQ requesters: round-robin intake,
// single-job launch, latency watchdog and a valid/ready response port.
module aes_job_scheduler
  import aes_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int SLACK = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0]           req_decrypt,
  input  logic [2*NREQ-1:0]         req_ksel,
  input  logic [AES_BLK*NREQ-1:0]   req_data,
  output logic                      eng_start,
  output logic                      eng_decrypt,
  output logic [1:0]                eng_ksel,
  output logic [AES_BLK-1:0]        eng_data_in,
  input  logic                      eng_done,
  input  logic [AES_BLK-1:0]        eng_data_out,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic                      rsp_err,
  output logic [AES_BLK-1:0]        rsp_data
);

  localparam int IW = $clog2(NREQ);

  state_e               state_q, state_d;
  logic [IW-1:0]        rr_q, rr_d;
  logic [IW-1:0]        id_q, id_d;
  logic                 dec_q, dec_d;
  logic [1:0]           ksel_q, ksel_d;
  logic [AES_BLK-1:0]   data_q, data_d;
  logic [4:0]           cnt_q, cnt_d;
  logic                 start_q, start_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [AES_BLK-1:0]   rsp_data_q, rsp_data_d;

  logic [NREQ-1:0]      gnt;
  logic [IW-1:0]        gnt_idx;
  logic                 gnt_any;
  logic [1:0]           gnt_ksel;
  logic [4:0]           cnt_inc;
  logic [5:0]           limit;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req_valid),
    .ptr   (rr_q),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  assign gnt_ksel = req_ksel[2*gnt_idx +: 2];
  assign cnt_inc  = (cnt_q == 5'h1f) ? cnt_q : cnt_q + 5'd1;
  assign limit    = 6'(nr_of(ksel_q)) + 6'(SLACK);

  // Grants are withheld while reset is asserted so every output reads 0.
  assign req_ready = (state_q == ST_IDLE && !reset) ? gnt : '0;

  always_comb begin
    // NOTE: every _d starts from its _q (or an idle value) so no path infers a latch.
    state_d     = state_q;
    rr_d        = rr_q;
    id_d        = id_q;
    dec_d       = dec_q;
    ksel_d      = ksel_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    start_d     = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          id_d   = gnt_idx;
          dec_d  = req_decrypt[gnt_idx];
          ksel_d = gnt_ksel;
          data_d = req_data[AES_BLK*gnt_idx +: AES_BLK];
          rr_d   = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
          cnt_d  = '0;
          if (gnt_ksel == KSEL_INV) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
          end else begin
            state_d = ST_LAUNCH;
            start_d = 1'b1;
          end
        end
      end
      ST_LAUNCH: state_d = ST_BUSY;
      ST_BUSY: begin
        // cnt_inc is the 1-based index of the current BUSY cycle.
        cnt_d = cnt_inc;
        if (eng_done) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = eng_data_out;
        end else if ({1'b0, cnt_inc} >= limit) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values computed before this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_q        <= '0;
      id_q        <= '0;
      dec_q       <= 1'b0;
      ksel_q      <= KSEL_INV;
      data_q      <= '0;
      cnt_q       <= '0;
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      id_q        <= id_d;
      dec_q       <= dec_d;
      ksel_q      <= ksel_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      start_q     <= start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign eng_start   = start_q;
  assign eng_decrypt = dec_q;
  assign eng_ksel    = ksel_q;
  assign eng_data_in = data_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = id_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_data    = rsp_data_q;

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Scoreboard bench for aes_job_scheduler with a behavioural engine model;
// expected responses are queued when jobs are offered and checked on handshake.
`timescale 1ns/1ps
module tb_aes_job_scheduler;
  import aes_pkg::*;

  localparam int NREQ  = 2;
  localparam int SLACK = 4;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_decrypt = '0;
  logic [2*NREQ-1:0]     req_ksel = '0;
  logic [128*NREQ-1:0]   req_data = '0;
  logic                  eng_start, eng_decrypt;
  logic [1:0]            eng_ksel;
  logic [127:0]          eng_data_in;
  logic                  eng_done = 1'b0;
  logic [127:0]          eng_data_out = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [0:0]            rsp_id;
  logic                  rsp_err;
  logic [127:0]          rsp_data;

  aes_job_scheduler #(.NREQ(NREQ), .SLACK(SLACK)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_decrypt(req_decrypt),
    .req_ksel(req_ksel), .req_data(req_data),
    .eng_start(eng_start), .eng_decrypt(eng_decrypt), .eng_ksel(eng_ksel),
    .eng_data_in(eng_data_in), .eng_done(eng_done), .eng_data_out(eng_data_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_err(rsp_err), .rsp_data(rsp_data)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [0:0]   id;
    logic         err;
    logic [127:0] data;
  } rsp_t;

  rsp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Engine stand-in: the known FIPS-197 vector for AES-128, a keyed shuffle otherwise.
  function automatic logic [127:0] eng_model(input logic [127:0] din, input logic dec,
                                             input logic [1:0] ks);
    if (!dec && ks == KSEL_128 && din == PT) return CT;
    return {din[63:0], din[127:64]} ^ {32{dec, 1'b1, ks}};
  endfunction

  function automatic logic [127:0] blk(input int r, input int k);
    return {4{8'(r) + 8'ha0, 24'(k) + 24'h001234}};
  endfunction

  int   cyc = 0;
  int   eng_lat = 10;
  bit   eng_mute = 1'b0;
  bit   kick = 1'b0;
  int   start_cnt = 0;
  int   last_start = -1;
  int   start_cyc[$];
  int   done_cyc = -1;
  int   rise_cyc = -1;
  int   viol = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Engine model: done is driven for the cycle start+eng_lat.
  initial begin
    int           cnt;
    logic [127:0] din;
    logic         dec;
    logic [1:0]   ks;
    cnt = 0;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (reset) cnt = 0;
      if (eng_start) begin
        start_cnt++;
        last_start = cyc;
        start_cyc.push_back(cyc);
        cnt = eng_lat;
        din = eng_data_in;
        dec = eng_decrypt;
        ks  = eng_ksel;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && !eng_mute) begin
          eng_done     = 1'b1;
          eng_data_out = eng_model(din, dec, ks);
          done_cyc     = cyc;
        end
      end
      if (kick) begin
        eng_done     = 1'b1;
        eng_data_out = '1;
        kick         = 1'b0;
      end
    end
  end

  // Response monitor: pops the scoreboard on every rsp handshake.
  initial begin
    rsp_t e;
    logic prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rsp_valid && !prev_v) rise_cyc = cyc;
      prev_v = rsp_valid;
      if (rsp_valid && req_ready != '0) viol++;
      if ($countones(req_ready) > 1) viol++;
      if (rsp_valid && rsp_ready) begin
        check("rsp_expected", 128'(exp_q.size() != 0), 128'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rsp_id", 128'(rsp_id), 128'(e.id));
          check("rsp_err", 128'(rsp_err), 128'(e.err));
          check("rsp_data", rsp_data, e.data);
        end
      end
    end
  end

  task automatic offer(input int r, input logic dec, input logic [1:0] ks, input logic [127:0] d);
    req_decrypt[r]       = dec;
    req_ksel[2*r +: 2]   = ks;
    req_data[128*r +: 128] = d;
    req_valid[r]         = 1'b1;
  endtask

  task automatic send(input int r, input logic dec, input logic [1:0] ks,
                      input logic [127:0] d, output int t);
    @(negedge clk);
    offer(r, dec, ks, d);
    t = -1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (req_ready[r]) begin
        t = cyc;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    req_valid[r] = 1'b0;
    check("accept", 128'(t >= 0), 128'd1);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    int           t, bad, rdy_bad, n;
    int           acc [2];
    logic [1:0]   hs;
    logic [129:0] snap;

    // Reset: all outputs zero even with requests pending.
    repeat (3) @(negedge clk);
    req_valid = 2'b11;
    #1;
    check("rst_ctrl", 128'({req_ready, eng_start, eng_decrypt, eng_ksel, rsp_valid, rsp_id, rsp_err}), 128'd0);
    check("rst_data", eng_data_in | rsp_data, 128'd0);
    req_valid = '0;
    @(negedge clk);
    reset = 1'b0;
    rsp_ready = 1'b1;

    // AES-128 known-answer job from requester 0.
    eng_lat = 10;
    rise_cyc = -1;
    exp_q.push_back('{id: 1'b0, err: 1'b0, data: CT});
    send(0, 1'b0, KSEL_128, PT, t);
    check("t1_start_lat", 128'(last_start - t), 128'd1);
    drain(40);
    check("t1_rsp_lat", 128'(rise_cyc - done_cyc), 128'd1);

    // Invalid key size from requester 1: immediate error, no launch.
    n = start_cnt;
    rise_cyc = -1;
    exp_q.push_back('{id: 1'b1, err: 1'b1, data: '0});
    send(1, 1'b0, KSEL_INV, blk(1, 99), t);
    drain(10);
    check("t2_rsp_lat", 128'(rise_cyc - t), 128'd1);
    check("t2_no_start", 128'(start_cnt), 128'(n));

    // Fairness: both requesters always valid with AES-256. Engine answers
    // Nr+1 cycles after start, giving an issue period of Nr+4 = 18.
    eng_lat = 15;
    start_cyc.delete();
    for (int j = 0; j < 8; j++)
      exp_q.push_back('{id: 1'(j % 2), err: 1'b0,
                        data: eng_model(blk(j % 2, j / 2), 1'b0, KSEL_256)});
    @(negedge clk);
    offer(0, 1'b0, KSEL_256, blk(0, 0));
    offer(1, 1'b0, KSEL_256, blk(1, 0));
    acc = '{0, 0};
    n = 0;
    for (int i = 0; i < 400 && n < 8; i++) begin
      #1;
      hs = req_ready & req_valid;
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
        if (hs[r]) begin
          acc[r]++;
          n++;
          req_data[128*r +: 128] = blk(r, acc[r]);
        end
      end
      if (n >= 8) req_valid = '0;
    end
    req_valid = '0;
    drain(100);
    check("t3_start_count", 128'(start_cyc.size()), 128'd8);
    for (int j = 1; j < 8 && j < start_cyc.size(); j++)
      check("t3_start_gap", 128'(start_cyc[j] - start_cyc[j-1]), 128'd18);

    // Watchdog: AES-192 with a silent engine, then a late done.
    eng_mute = 1'b1;
    rise_cyc = -1;
    exp_q.push_back('{id: 1'b0, err: 1'b1, data: '0});
    send(0, 1'b0, KSEL_192, blk(0, 50), t);
    drain(60);
    // Start in S, BUSY cycles S+1..S+16, response in S+17.
    check("t4_timeout_lat", 128'(rise_cyc - last_start), 128'd17);
    repeat (2) @(negedge clk);
    kick = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (rsp_valid) bad++;
    end
    check("t4_late_done_ignored", 128'(bad), 128'd0);
    eng_mute = 1'b0;

    // Backpressure on an AES-192 decrypt result; also confirms IDLE after the late done.
    eng_lat = 12;
    rsp_ready = 1'b0;
    exp_q.push_back('{id: 1'b1, err: 1'b0, data: eng_model(blk(1, 60), 1'b1, KSEL_192)});
    offer(1, 1'b1, KSEL_192, blk(1, 60));
    #1;
    check("t4_idle_ready", 128'(req_ready), 128'(2'b10));
    @(negedge clk);
    req_valid = '0;
    for (int i = 0; i < 60 && !rsp_valid; i++) begin
      @(negedge clk);
      #1;
    end
    check("t5_valid", 128'(rsp_valid), 128'd1);
    snap = {rsp_id, rsp_err, rsp_data};
    offer(0, 1'b0, KSEL_128, blk(0, 70));
    bad = 0;
    rdy_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (!rsp_valid || {rsp_id, rsp_err, rsp_data} !== snap) bad++;
      if (req_ready != '0) rdy_bad++;
    end
    check("t5_rsp_stable", 128'(bad), 128'd0);
    check("t5_req_ready_low", 128'(rdy_bad), 128'd0);
    req_valid = '0;
    rsp_ready = 1'b1;
    drain(10);

    // Reset mid-BUSY, stale done afterwards, then fresh arbitration from 0.
    eng_mute = 1'b1;
    send(0, 1'b0, KSEL_128, blk(0, 80), t);
    repeat (4) @(negedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("t6_rst_ctrl", 128'({req_ready, eng_start, eng_decrypt, eng_ksel, rsp_valid, rsp_id, rsp_err}), 128'd0);
    check("t6_rst_data", eng_data_in | rsp_data, 128'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    kick = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (rsp_valid || eng_start) bad++;
    end
    check("t6_no_rsp", 128'(bad), 128'd0);
    check("t6_idle_data", eng_data_in | rsp_data, 128'd0);
    eng_mute = 1'b0;
    eng_lat = 10;
    exp_q.push_back('{id: 1'b0, err: 1'b0, data: eng_model(blk(0, 90), 1'b0, KSEL_128)});
    offer(0, 1'b0, KSEL_128, blk(0, 90));
    offer(1, 1'b0, KSEL_128, blk(1, 90));
    #1;
    check("t6_grant_after_reset", 128'(req_ready), 128'(2'b01));
    @(negedge clk);
    req_valid = '0;
    drain(40);

    check("req_rsp_overlap", 128'(viol), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
